// File: rtl/imem_loader_pkg.sv
// Shared constants for the IMEM loader: address width, FSM encodings, session record.
// CHECK exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int IMEM_AW = 14;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd3;
`endif
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [IMEM_AW-1:0] addr;
    logic [IMEM_AW-1:0] cnt;
  } session_t;

  // Word address step; the carry out of the top bit is dropped, so 3FFF wraps to 0000.
  function automatic logic [IMEM_AW-1:0] addr_inc(input logic [IMEM_AW-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte 0 -> [7:0] ... byte 3 -> [31:24].
// word_valid_o flags the fourth byte; word_o carries the complete word from the next cycle on.
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic [3:0]  lane_we;
  logic [31:0] word_q;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (valid_i) begin
      idx_d = 2'(idx_q + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_we[gi] = valid_i && !clear_i && (idx_q == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q[gi*8 +: 8] <= 8'h00;
        end else if (lane_we[gi]) begin
          word_q[gi*8 +: 8] <= byte_i;
        end
      end
    end
  endgenerate

  assign word_o       = word_q;
  assign word_valid_o = lane_we[3];

endmodule

// File: rtl/imem_loader.sv
// Streams host bytes into IMEM as 32-bit words while holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing mod-256 checksum byte and the CHECK state.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW-1:0] base_addr,
  input  logic [IMEM_AW-1:0] word_cnt,
  input  logic               abort,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_ena,
  output logic [3:0]         imem_wea,
  output logic [IMEM_AW-1:0] imem_addra,
  output logic [31:0]        imem_dina,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               core_rst_hold
);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  session_t    sess_q;
  session_t    sess_d;
  logic        err_q;
  logic        err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
  logic [7:0]  sum_d;
`endif

  logic        in_recv;
  logic        in_write;
  logic        rx_fire;
  logic        pk_clear;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        pk_word_valid;

  assign in_recv  = (state_q == ST_RECV);
  assign in_write = (state_q == ST_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready = in_recv || (state_q == ST_CHECK);
`else
  assign rx_ready = in_recv;
`endif
  assign rx_fire  = rx_valid && rx_ready;

  // Abort or an idle FSM drops any partially assembled word.
  assign pk_clear = abort || (state_q == ST_IDLE);
  assign pk_valid = rx_fire && in_recv;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (rx_data),
    .valid_i      (pk_valid),
    .clear_i      (pk_clear),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d = state_q;
    sess_d  = sess_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sess_d.addr = base_addr;
            sess_d.cnt  = word_cnt;
            err_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d       = 8'h00;
`endif
            state_d     = (word_cnt == '0) ? ST_DONE : ST_RECV;
          end
        end
        ST_RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (rx_fire) begin
            sum_d = 8'(sum_q + rx_data);
          end
`endif
          if (pk_word_valid) begin
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          sess_d.addr = addr_inc(sess_q.addr);
          sess_d.cnt  = sess_q.cnt - 14'd1;
          if (sess_q.cnt == 14'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_RECV;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_fire) begin
            if (8'(sum_q + rx_data) != 8'h00) begin
              err_d = 1'b1;
            end
            state_d = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sess_q  <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      sess_q  <= sess_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Write port is decoded from the state, so an abort during WRITE still lets that write land.
  assign imem_ena      = in_write;
  assign imem_wea      = {4{in_write}};
  assign imem_addra    = in_write ? sess_q.addr : '0;
  assign imem_dina     = in_write ? pk_word : 32'h0;
  assign busy          = (state_q != ST_IDLE);
  assign core_rst_hold = busy;
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;

endmodule
